// File: rtl/fpd_link_serializer.sv
// FPD-Link style 7:1 pixel serializer: samples one pixel every seven clocks and
// shifts it out MSB-mapped across 3 (18-bit) or 4 (24-bit) data lanes plus a clock lane.
module fpd_link_serializer #(
   parameter int COLOR_BITS = 6,
   localparam int LANES = (COLOR_BITS == 8) ? 4 : 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_map_jeida,
   input  logic                  i_de,
   input  logic                  i_vs,
   input  logic                  i_hs,
   input  logic [COLOR_BITS-1:0] i_r,
   input  logic [COLOR_BITS-1:0] i_g,
   input  logic [COLOR_BITS-1:0] i_b,
   output logic                  o_pix_req,
   output logic [LANES-1:0]      o_tdms,
   output logic                  o_clk_lane
);

   localparam int CB = COLOR_BITS;
   localparam int SW = 3 * CB + 4;
   localparam logic [6:0] CLK_PATTERN = 7'b1100011;

   logic [2:0]       r_ph;
   logic [SW-1:0]    r_shadow;
   logic [LANES-1:0] r_tdms;
   logic             r_clkLane;

   logic             w_sample;
   logic [2:0]       w_nextPh;
   logic [SW-1:0]    w_in;
   logic [SW-1:0]    w_src;
   logic             w_srcDe;
   logic             w_srcVs;
   logic             w_srcHs;
   logic             w_srcJeida;
   logic             w_useJeida;
   logic [CB-1:0]    w_srcR;
   logic [CB-1:0]    w_srcG;
   logic [CB-1:0]    w_srcB;
   logic [5:0]       w_rc;
   logic [5:0]       w_gc;
   logic [5:0]       w_bc;
   logic [6:0]       w_lane0;
   logic [6:0]       w_lane1;
   logic [6:0]       w_lane2;
   logic [LANES-1:0][6:0] w_words;

   // Phase 0 of a pixel comes straight from the inputs at the sample edge,
   // later phases come from the shadow copy taken on that same edge.
   assign w_sample = (r_ph == 3'd6);
   assign w_nextPh = w_sample ? 3'd0 : r_ph + 3'd1;
   assign w_in     = {i_de, i_vs, i_hs, i_r, i_g, i_b, i_map_jeida};
   assign w_src    = w_sample ? w_in : r_shadow;

   assign w_srcDe    = w_src[SW-1];
   assign w_srcVs    = w_src[SW-2];
   assign w_srcHs    = w_src[SW-3];
   assign w_srcR     = w_src[SW-4 -: CB];
   assign w_srcG     = w_src[SW-4-CB -: CB];
   assign w_srcB     = w_src[CB:1];
   assign w_srcJeida = w_src[0];
   assign w_useJeida = (COLOR_BITS == 8) && w_srcJeida;

   // JEIDA puts the colour MSBs on the three base lanes; VESA puts the LSBs there.
   assign w_rc = w_useJeida ? w_srcR[CB-1 -: 6] : w_srcR[5:0];
   assign w_gc = w_useJeida ? w_srcG[CB-1 -: 6] : w_srcG[5:0];
   assign w_bc = w_useJeida ? w_srcB[CB-1 -: 6] : w_srcB[5:0];

   assign w_lane0 = {w_rc[0], w_rc[1], w_rc[2], w_rc[3], w_rc[4], w_rc[5], w_gc[0]};
   assign w_lane1 = {w_gc[1], w_gc[2], w_gc[3], w_gc[4], w_gc[5], w_bc[0], w_bc[1]};
   assign w_lane2 = {w_bc[2], w_bc[3], w_bc[4], w_bc[5], w_srcHs, w_srcVs, w_srcDe};

   generate
      if (LANES == 4) begin : gLane3
         logic [1:0] w_rx;
         logic [1:0] w_gx;
         logic [1:0] w_bx;
         logic [6:0] w_lane3;
         assign w_rx    = w_useJeida ? w_srcR[1:0] : w_srcR[CB-1 -: 2];
         assign w_gx    = w_useJeida ? w_srcG[1:0] : w_srcG[CB-1 -: 2];
         assign w_bx    = w_useJeida ? w_srcB[1:0] : w_srcB[CB-1 -: 2];
         assign w_lane3 = {w_rx[0], w_rx[1], w_gx[0], w_gx[1], w_bx[0], w_bx[1], 1'b0};
         assign w_words = {w_lane3, w_lane2, w_lane1, w_lane0};
      end else begin : gNoLane3
         assign w_words = {w_lane2, w_lane1, w_lane0};
      end
   endgenerate

   // Disable parks the counter at the sample phase so re-enable starts a whole pixel.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ph      <= 3'd6;
         r_shadow  <= '0;
         r_tdms    <= '0;
         r_clkLane <= 1'b0;
      end else if (!i_en) begin
         r_ph      <= 3'd6;
         r_tdms    <= '0;
         r_clkLane <= 1'b0;
      end else begin
         if (w_sample) begin
            r_shadow <= w_in;
         end
         r_ph <= w_nextPh;
         for (int l = 0; l < LANES; l++) begin
            r_tdms[l] <= w_words[l][w_nextPh];
         end
         r_clkLane <= CLK_PATTERN[w_nextPh];
      end
   end

   assign o_pix_req  = i_en & w_sample;
   assign o_tdms     = r_tdms;
   assign o_clk_lane = r_clkLane;

endmodule

// File: doc/fpd_link_serializer.md
FPD_LINK_SERIALIZER -- requirements
Module: fpd_link_serializer

Interface
REQ-001 Parameter COLOR_BITS, default 6, meaning per-colour width; legal values 6 or 8 only.
REQ-002 Parameter LANES, derived as 3 when COLOR_BITS=6 and 4 when COLOR_BITS=8; not overridable.
REQ-003 clk  input  1  bit clock, 7x pixel rate; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  serializer enable.
REQ-006 map_jeida  input  1  8-bit lane mapping select (0 VESA, 1 JEIDA); ignored when COLOR_BITS=6.
REQ-007 de, vs, hs  input  1 each  data enable, vertical sync, horizontal sync.
REQ-008 r, g, b  input  COLOR_BITS each  pixel colour.
REQ-009 pix_req  output  1  pixel strobe; inputs are sampled on the edge ending a cycle with pix_req=1.
REQ-010 tdms  output  LANES  registered serial data, one bit per lane per clk.
REQ-011 clk_lane  output  1  registered serial pixel-clock lane.

Function
REQ-012 Phase counter ph, 3 bits, values 0..6; advances 0->1->...->6->0 on each edge with en=1; ph never holds value 7.
REQ-013 pix_req = en AND (ph==6), decoded from the registered ph.
REQ-014 On an edge with en=1 and ph=6: shadow <= {de,vs,hs,r,g,b,map_jeida}; tdms <= phase-0 bits of the incoming (not shadow) pixel; ph <= 0.
REQ-015 On an edge with en=1 and ph=k, k in 0..5: tdms <= phase-(k+1) bits of shadow; ph <= k+1.
REQ-016 Result: during a cycle with ph=p, tdms carries bit p of the pixel sampled at the preceding ph=6 edge; latency from sample edge to first bit is 1 cycle.
REQ-017 clk_lane follows the same registration rule with phase pattern 0..6 = 1,1,0,0,0,1,1.
REQ-018 Let c[5:0] denote the 6-bit field per colour: VESA or COLOR_BITS=6: c = colour[5:0]; JEIDA: c = colour[7:2].
REQ-019 Lane 0, phases 0..6: G.c0, R.c5, R.c4, R.c3, R.c2, R.c1, R.c0.
REQ-020 Lane 1, phases 0..6: B.c1, B.c0, G.c5, G.c4, G.c3, G.c2, G.c1.
REQ-021 Lane 2, phases 0..6: de, vs, hs, B.c5, B.c4, B.c3, B.c2.
REQ-022 Lane 3 (LANES=4 only), phases 0..6: 0, B.x1, B.x0, G.x1, G.x0, R.x1, R.x0; x = colour[7:6] for VESA, colour[1:0] for JEIDA.
REQ-023 The mapping used for a pixel's phases 1..6 is the shadowed map_jeida; a map_jeida change mid-pixel takes effect only at the next ph=6 edge.
REQ-024 Inputs are ignored on every edge except en=1, ph=6; changes at other times do not affect tdms.
REQ-025 On an edge with en=0: ph <= 6, tdms <= 0, clk_lane <= 0, shadow held; pix_req is 0 while en=0.
REQ-026 en rising: the first edge with en=1 samples a pixel (ph=6) and tdms shows phase 0 in the next cycle; no partial pixel is ever emitted.
REQ-027 en falling mid-pixel: the current pixel is abandoned at that edge; outputs go to 0 per REQ-025.
REQ-028 rst has priority over en on the same edge.

Reset
REQ-029 On an edge with rst=1: ph <= 6, tdms <= 0, clk_lane <= 0, shadow <= 0; pix_req = en after reset releases (ph=6).
REQ-030 rst asserted mid-pixel abandons the pixel; after release, the first en=1 edge samples a new pixel per REQ-026.

Verification
REQ-031 COLOR_BITS=6, en=1, de=1 vs=0 hs=1, r=6'h2A g=6'h15 b=6'h33 -> lane0 phases 0..6 = 1,1,0,1,0,1,0; lane1 = 1,1,0,1,0,1,0; lane2 = 1,0,1,1,1,0,0; clk_lane = 1,1,0,0,0,1,1.
REQ-032 Continuous en=1 for 70 clks -> pix_req pulses exactly every 7th cycle (10 pulses); clk_lane period 7 with no gap across pixel boundaries.
REQ-033 COLOR_BITS=8, r=8'hC1, g=b=0, vs=hs=de=0, map_jeida=0 -> lane3 = 0,0,0,0,0,1,1 and lane0 = 0,0,0,0,0,0,1; same pixel with map_jeida=1 -> lane3 = 0,0,0,0,0,0,1 and lane0 = 0,1,1,0,0,0,0.
REQ-034 Toggle r and map_jeida at ph=3 -> tdms phases 4..6 unchanged; new values appear only from the next pixel.
REQ-035 en dropped at ph=4 for 3 cycles, then raised -> tdms=0, clk_lane=0, pix_req=0 while low; first cycle after re-enable edge shows phase 0 of freshly sampled pixel.
REQ-036 rst pulsed for 1 cycle at ph=2 with en=1 -> next cycle tdms=0, clk_lane=0, pix_req=1; following cycle begins a complete new pixel at phase 0.
